// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared constants and types for the reorder-buffer allocation controller.
//   ROB_INDEX_WIDTH : width of a ROB index
//   ROB_DEPTH       : number of ROB entries (2**ROB_INDEX_WIDTH)
//   RECOVER_CYCLES  : dispatch-blocked cycles that follow a flush cycle
//   rob_state_e     : controller state encoding (RUN / RECOVER)
//   commit_count()  : in-order commit count from the head completion flags
package rob_alloc_ctrl_pkg;

  localparam int ROB_INDEX_WIDTH = 5;
  localparam int ROB_DEPTH       = 1 << ROB_INDEX_WIDTH;
  localparam int RECOVER_CYCLES  = 2;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } rob_state_e;

  // Commits retire strictly in order: head+1 can only go if head goes too,
  // and only if it is actually a live entry.
  function automatic logic [1:0] commit_count(input logic [1:0] ready,
                                              input logic       has_one,
                                              input logic       has_two);
    logic [1:0] n;
    n = 2'd0;
    if (has_one && ready[0]) begin
      n = (ready[1] && has_two) ? 2'd2 : 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/rob_alloc_ctrl_disp_arb.sv
// rob_disp_arb: combinational in-order two-slot dispatch arbiter.
//   disp_req   : request per slot (slot0 is older)
//   block      : suppresses every grant (reset, flush, recovery)
//   count      : registered live-entry count (pre-commit)
//   tail       : next free ROB index
//   grant      : grant per slot
//   idx0/idx1  : ROB index handed to slot0/slot1 (valid only when granted)
//   num_grants : number of grants issued (0..2)
module rob_disp_arb #(
  parameter int INDEX_WIDTH = 5,
  parameter int DEPTH       = 32
) (
  input  logic [1:0]             disp_req,
  input  logic                   block,
  input  logic [INDEX_WIDTH:0]   count,
  input  logic [INDEX_WIDTH-1:0] tail,
  output logic [1:0]             grant,
  output logic [INDEX_WIDTH-1:0] idx0,
  output logic [INDEX_WIDTH-1:0] idx1,
  output logic [1:0]             num_grants
);

  logic [INDEX_WIDTH:0] free_slots;
  logic                 has_one;
  logic                 has_two;

  // Uses the pre-commit count: space freed by this cycle's commits is not
  // visible to dispatch until the next cycle.
  assign free_slots = (INDEX_WIDTH+1)'(DEPTH) - count;
  assign has_one    = (free_slots != '0);
  assign has_two    = (free_slots > (INDEX_WIDTH+1)'(1));

  always_comb begin
    grant = 2'b00;
    if (!block) begin
      grant[0] = disp_req[0] && has_one;
      // slot1 is the second allocation only when slot0 also requests
      grant[1] = disp_req[1] && (disp_req[0] ? has_two : has_one);
    end
  end

  assign idx0       = tail;
  assign idx1       = disp_req[0] ? tail + INDEX_WIDTH'(1) : tail;
  assign num_grants = {1'b0, grant[0]} + {1'b0, grant[1]};

endmodule

// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl: ROB head/tail/count bookkeeping with 2-wide dispatch,
// 2-wide in-order commit, and flush recovery.
//   clk, rst             : clock, synchronous active-high reset
//   disp_req_i           : dispatch request per slot
//   disp_grant_o         : allocation granted per slot
//   disp_idx0_o/idx1_o   : ROB index of slot0/slot1 allocation
//   head_ready_i         : completion flags of head and head+1
//   comcnt_o             : entries committed this cycle
//   flush_i, flush_idx_i : squash request and oldest squashed index
//   head_o, tail_o       : oldest live entry, next free entry
//   count_o              : live entries
//   full_o, empty_o      : fewer than 2 free / no live entries
//   stall_o              : dispatch blocked
//   state_o              : 0 = RUN, 1 = RECOVER
module rob_alloc_ctrl #(
  parameter int INDEX_WIDTH    = rob_alloc_ctrl_pkg::ROB_INDEX_WIDTH,
  parameter int DEPTH          = rob_alloc_ctrl_pkg::ROB_DEPTH,
  parameter int RECOVER_CYCLES = rob_alloc_ctrl_pkg::RECOVER_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             disp_req_i,
  output logic [1:0]             disp_grant_o,
  output logic [INDEX_WIDTH-1:0] disp_idx0_o,
  output logic [INDEX_WIDTH-1:0] disp_idx1_o,
  input  logic [1:0]             head_ready_i,
  output logic [1:0]             comcnt_o,
  input  logic                   flush_i,
  input  logic [INDEX_WIDTH-1:0] flush_idx_i,
  output logic [INDEX_WIDTH-1:0] head_o,
  output logic [INDEX_WIDTH-1:0] tail_o,
  output logic [INDEX_WIDTH:0]   count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   stall_o,
  output logic                   state_o
);

  import rob_alloc_ctrl_pkg::*;

  localparam int RCNT_W = (RECOVER_CYCLES < 2) ? 1 : $clog2(RECOVER_CYCLES + 1);
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RECOVER_CYCLES);

  rob_state_e             state_reg, state_next;
  logic [RCNT_W-1:0]      rcnt_reg, rcnt_next;
  logic [INDEX_WIDTH-1:0] head_reg, head_next;
  logic [INDEX_WIDTH-1:0] tail_reg, tail_next;
  logic [INDEX_WIDTH:0]   count_reg, count_next;

  logic                   block;
  logic [1:0]             grant;
  logic [1:0]             num_grants;
  logic [1:0]             comcnt;
  logic [INDEX_WIDTH-1:0] head_after_commit;
  logic [INDEX_WIDTH:0]   free_slots;

  // ---------------------------------------------------------------- dispatch
  assign block = rst || flush_i || (state_reg == ST_RECOVER);

  rob_disp_arb #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .DEPTH       (DEPTH)
  ) u_disp_arb (
    .disp_req   (disp_req_i),
    .block      (block),
    .count      (count_reg),
    .tail       (tail_reg),
    .grant      (grant),
    .idx0       (disp_idx0_o),
    .idx1       (disp_idx1_o),
    .num_grants (num_grants)
  );

  // ------------------------------------------------------------------ commit
  // Commits keep running through flush and recovery; only reset stops them.
  always_comb begin
    comcnt = 2'd0;
    if (!rst) begin
      comcnt = commit_count(head_ready_i,
                            count_reg != '0,
                            count_reg > (INDEX_WIDTH+1)'(1));
    end
  end

  assign head_after_commit = head_reg + INDEX_WIDTH'(comcnt);

  // ---------------------------------------------------- pointers and count
  always_comb begin
    head_next  = head_after_commit;
    tail_next  = tail_reg + INDEX_WIDTH'(num_grants);
    count_next = count_reg + (INDEX_WIDTH+1)'(num_grants)
                           - (INDEX_WIDTH+1)'(comcnt);
    if (flush_i) begin
      // Everything from flush_idx_i onward is discarded; the survivors are
      // the entries between the post-commit head and the squash point.
      tail_next  = flush_idx_i;
      count_next = {1'b0, flush_idx_i - head_after_commit};
    end
  end

  // --------------------------------------------------------------------- FSM
  always_comb begin
    state_next = state_reg;
    rcnt_next  = rcnt_reg;
    if (flush_i) begin
      rcnt_next = RCNT_LOAD;
      if (RECOVER_CYCLES > 0) begin
        state_next = ST_RECOVER;
      end
    end else if (state_reg == ST_RECOVER) begin
      // Leave on the cycle whose decrement brings the counter to zero, so
      // RECOVER occupies exactly RECOVER_CYCLES cycles.
      if (rcnt_reg <= RCNT_W'(1)) begin
        state_next = ST_RUN;
        rcnt_next  = '0;
      end else begin
        rcnt_next = rcnt_reg - RCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      rcnt_reg  <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      rcnt_reg  <= rcnt_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // ----------------------------------------------------------------- outputs
  assign free_slots   = (INDEX_WIDTH+1)'(DEPTH) - count_reg;
  assign disp_grant_o = grant;
  assign comcnt_o     = comcnt;
  assign head_o       = head_reg;
  assign tail_o       = tail_reg;
  assign count_o      = count_reg;
  assign full_o       = (free_slots < (INDEX_WIDTH+1)'(2));
  assign empty_o      = (count_reg == '0);
  assign stall_o      = full_o || (state_reg == ST_RECOVER) || flush_i;
  assign state_o      = state_reg;

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed + constrained-random bench for rob_alloc_ctrl. Each step drives
// one cycle of inputs, pushes the expected outputs for that cycle to a
// scoreboard queue and advances a reference model; a negedge monitor pops
// and compares.
module tb_rob_alloc_ctrl;

  localparam int IW = 5;
  localparam int D  = 32;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    disp_req_i;
  logic [1:0]    disp_grant_o;
  logic [IW-1:0] disp_idx0_o;
  logic [IW-1:0] disp_idx1_o;
  logic [1:0]    head_ready_i;
  logic [1:0]    comcnt_o;
  logic          flush_i;
  logic [IW-1:0] flush_idx_i;
  logic [IW-1:0] head_o;
  logic [IW-1:0] tail_o;
  logic [IW:0]   count_o;
  logic          full_o;
  logic          empty_o;
  logic          stall_o;
  logic          state_o;

  always #5 clk = ~clk;

  rob_alloc_ctrl #(.INDEX_WIDTH(IW), .DEPTH(D), .RECOVER_CYCLES(RC)) dut (
    .clk          (clk),
    .rst          (rst),
    .disp_req_i   (disp_req_i),
    .disp_grant_o (disp_grant_o),
    .disp_idx0_o  (disp_idx0_o),
    .disp_idx1_o  (disp_idx1_o),
    .head_ready_i (head_ready_i),
    .comcnt_o     (comcnt_o),
    .flush_i      (flush_i),
    .flush_idx_i  (flush_idx_i),
    .head_o       (head_o),
    .tail_o       (tail_o),
    .count_o      (count_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .stall_o      (stall_o),
    .state_o      (state_o)
  );

  typedef struct {
    int         step;
    logic [1:0] grant;
    logic [IW-1:0] idx0;
    logic [IW-1:0] idx1;
    logic [1:0] comcnt;
    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [IW:0]   count;
    logic       full;
    logic       empty;
    logic       stall;
    logic       state;
  } exp_t;

  exp_t sb_q[$];

  int checks  = 0;
  int passes  = 0;
  int fails   = 0;
  int step_no = 0;

  // reference model state
  int m_head, m_tail, m_count, m_state, m_rc;

  task automatic chk(input string tag, input int stp, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    assert (act === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, stp, act, exp_v);
    end
  endtask

  function automatic int model_com(input bit r, input logic [1:0] hr);
    if (r || m_count == 0 || !hr[0]) return 0;
    if (hr == 2'b11 && m_count >= 2) return 2;
    return 1;
  endfunction

  task automatic step(input bit r, input logic [1:0] req, input logic [1:0] hr,
                      input bit fl, input int fidx);
    exp_t e;
    int   com, free_n, ng, avail, off;
    bit   g0, g1;
    @(posedge clk);
    #1;
    rst          = r;
    disp_req_i   = req;
    head_ready_i = hr;
    flush_i      = fl;
    flush_idx_i  = IW'(fidx);

    com    = model_com(r, hr);
    free_n = D - m_count;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!r && !fl && m_state == 0) begin
      g0 = req[0] && (free_n >= 1);
      g1 = req[1] && (req[0] ? (free_n >= 2) : (free_n >= 1));
    end
    e.step   = step_no;
    e.grant  = {g1, g0};
    e.idx0   = IW'(m_tail);
    e.idx1   = g0 ? IW'(m_tail + 1) : IW'(m_tail);
    e.comcnt = 2'(com);
    e.head   = IW'(m_head);
    e.tail   = IW'(m_tail);
    e.count  = (IW+1)'(m_count);
    e.full   = (free_n < 2);
    e.empty  = (m_count == 0);
    e.stall  = (free_n < 2) || (m_state == 1) || fl;
    e.state  = (m_state == 1);
    sb_q.push_back(e);

    if (fl && !r) begin
      // flush target must be a surviving live entry
      avail = m_count - com;
      off   = (fidx - (m_head + com)) & (D - 1);
      chk("flush_precondition", step_no, 32'(off < avail), 32'd1);
    end

    ng = int'(g0) + int'(g1);
    if (r) begin
      m_head = 0; m_tail = 0; m_count = 0; m_state = 0; m_rc = 0;
    end else begin
      if (fl) begin
        m_count = (fidx - (m_head + com)) & (D - 1);
        m_tail  = fidx & (D - 1);
        m_state = 1;
        m_rc    = RC;
      end else begin
        m_tail  = (m_tail + ng) % D;
        m_count = m_count + ng - com;
        if (m_state == 1) begin
          if (m_rc <= 1) begin
            m_state = 0;
            m_rc    = 0;
          end else begin
            m_rc = m_rc - 1;
          end
        end
      end
      m_head = (m_head + com) % D;
    end
    step_no++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("grant", e.step, 32'(disp_grant_o), 32'(e.grant));
      if (e.grant[0]) chk("idx0", e.step, 32'(disp_idx0_o), 32'(e.idx0));
      if (e.grant[1]) chk("idx1", e.step, 32'(disp_idx1_o), 32'(e.idx1));
      chk("comcnt", e.step, 32'(comcnt_o), 32'(e.comcnt));
      chk("head",   e.step, 32'(head_o),   32'(e.head));
      chk("tail",   e.step, 32'(tail_o),   32'(e.tail));
      chk("count",  e.step, 32'(count_o),  32'(e.count));
      chk("full",   e.step, 32'(full_o),   32'(e.full));
      chk("empty",  e.step, 32'(empty_o),  32'(e.empty));
      chk("stall",  e.step, 32'(stall_o),  32'(e.stall));
      chk("state",  e.step, 32'(state_o),  32'(e.state));
      $display("step %0d rst=%0b req=%b hr=%b fl=%0b fidx=%0d | grant=%b idx=(%0d,%0d) com=%0d head=%0d tail=%0d count=%0d st=%0b",
               e.step, rst, disp_req_i, head_ready_i, flush_i, flush_idx_i,
               disp_grant_o, disp_idx0_o, disp_idx1_o, comcnt_o, head_o,
               tail_o, count_o, state_o);
    end
  end

  initial begin
    int com, avail, fidx;
    logic [1:0] req, hr;
    bit fl;

    rst = 1'b1; disp_req_i = 2'b00; head_ready_i = 2'b00;
    flush_i = 1'b0; flush_idx_i = '0;
    m_head = 0; m_tail = 0; m_count = 0; m_state = 0; m_rc = 0;
    repeat (2) @(posedge clk);

    // reset cycle with dispatch and flush asserted: no grants
    step(1, 2'b11, 2'b11, 1'b1, 0);
    // commit on empty ROB
    step(0, 2'b00, 2'b11, 1'b0, 0);

    // dual dispatch: (0,1),(2,3),(4,5)
    repeat (3) step(0, 2'b11, 2'b00, 1'b0, 0);
    // fill to 31
    repeat (12) step(0, 2'b11, 2'b00, 1'b0, 0);
    step(0, 2'b01, 2'b00, 1'b0, 0);
    // only slot0 fits: idx 31, tail wraps
    step(0, 2'b11, 2'b00, 1'b0, 0);
    // full: commit two, no grant
    step(0, 2'b11, 2'b11, 1'b0, 0);
    step(0, 2'b00, 2'b00, 1'b0, 0);

    // head=4, tail=12 then flush at 8 with one commit
    step(1, 2'b00, 2'b00, 1'b0, 0);
    repeat (6) step(0, 2'b11, 2'b00, 1'b0, 0);
    repeat (2) step(0, 2'b00, 2'b11, 1'b0, 0);
    step(0, 2'b11, 2'b01, 1'b1, 8);
    repeat (2) step(0, 2'b11, 2'b00, 1'b0, 0);
    step(0, 2'b11, 2'b00, 1'b0, 0);

    // flush, then a second flush mid-recovery
    step(0, 2'b11, 2'b00, 1'b1, 7);
    step(0, 2'b11, 2'b00, 1'b0, 0);
    step(0, 2'b11, 2'b00, 1'b1, 6);
    repeat (2) step(0, 2'b11, 2'b00, 1'b0, 0);
    step(0, 2'b01, 2'b00, 1'b0, 0);

    // reset mid-recovery
    step(0, 2'b00, 2'b00, 1'b1, 6);
    step(0, 2'b11, 2'b00, 1'b0, 0);
    step(1, 2'b11, 2'b11, 1'b1, 3);
    step(0, 2'b00, 2'b00, 1'b0, 0);

    // random traffic with occasional legal flushes
    for (int i = 0; i < 80; i++) begin
      req  = 2'($urandom_range(0, 3));
      hr   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      fl   = ($urandom_range(0, 11) == 0);
      fidx = 0;
      if (fl) begin
        com   = model_com(0, hr);
        avail = m_count - com;
        if (avail < 1) fl = 1'b0;
        else fidx = (m_head + com + int'($urandom_range(0, avail - 1))) % D;
      end
      step(0, req, hr, fl, fidx);
    end

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      fails++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
